time_digit_display: RTL and testbench
=====================================

// Module: time_digit_display
// PURPOSE
//  Reader/display end of the countdown-timer digit interface. Takes the three
//  BCD time digits (minutes, tens-of-seconds, seconds), snapshots them once
//  per scan frame, and time-multiplexes them onto the 4-digit 7-segment
//  display as M.SS. Blinks the whole display while the shown time is 0.00.
// PARAMETERS
//  REFRESH_DIV  100000    clk_in cycles each digit slot is held (~1 kHz/slot @100 MHz)
//  BLINK_DIV    25000000  clk_in cycles per blink half-period (2 Hz blink @100 MHz)
// PORTS
//  clk_in      in   1  system clock; all state on rising edge
//  reset       in   1  synchronous, active-high
//  en          in   1  1 = display lit; 0 = all anodes off, scanning continues
//  min_digit   in   4  minutes digit, BCD 0-9
//  tens_digit  in   4  tens-of-seconds digit, BCD 0-5
//  ones_digit  in   4  seconds digit, BCD 0-9
//  an          out  4  anode enables, active-low, an[0] = rightmost digit
//  seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1  decimal point, active-low
//  expired     out  1  1 while snapshot digits are all zero
// BEHAVIOUR
//  Reset (reset=1 at edge): an=4'b1111, seg=7'h7F, dp=1, expired=0, refresh
//   cnt=0, slot=0, snapshot=0, blink cnt=0, blink phase=0. Reset mid-scan
//   takes effect at that edge; no partial frame continues.
//  Refresh counter: 0..REFRESH_DIV-1, wraps; at terminal count slot advances
//   0->1->2->3->0 (2-bit wrap).
//  Snapshot: on the edge where slot wraps 3->0, min/tens/ones snapshot regs
//   load the inputs. Input changes at any other time are invisible until the
//   next frame boundary (no tearing within a frame).
//  expired = (all three snapshot digits == 0); registered, updates with snapshot.
//   Note: after reset the snapshot is 0, so expired=1 from the first cycle
//   after reset release until the first frame boundary loads nonzero digits.
//  Blink: while expired=1, blink counter runs 0..BLINK_DIV-1; phase toggles at
//   terminal count. While expired=0, counter and phase held at 0 (restart
//   always begins visible).
//  Slot mapping (combinational select, outputs registered; outputs reflect
//   the current slot 1 cycle later):
//   slot0: an=1110, seg=dec(ones), dp=1
//   slot1: an=1101, seg=dec(tens, limit 5), dp=1
//   slot2: an=1011, seg=dec(min), dp=0 (M.SS separator)
//   slot3: an=1111, seg=7'h7F, dp=1 (leftmost digit dark)
//  Blanking: en=0 or (expired and phase=1) -> an=1111, seg=7'h7F, dp=1.
//  dec(): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000; digit >9 (or tens >5) ->
//   '-' = 0111111.
//  en=0 does not stop refresh, snapshot or blink counters.
// TESTING (bench uses REFRESH_DIV=4, BLINK_DIV=8)
//  1 Hold reset 3 cycles -> an=1111 seg=7F dp=1 expired=0; first edge after
//    release -> an=1110 seg=1000000 (snapshot 0), expired=1.
//  2 Inputs min=1 tens=2 ones=3, after one frame boundary -> each slot held 4
//    cycles: an=1110/seg=0110000, 1101/0100100, 1011/1111001 dp=0, 1111/7F.
//  3 Change ones 3->7 while slot=1 -> remainder of frame still shows 3; 7
//    (1111000) appears only in slot0 of the next frame.
//  4 tens=6 -> slot1 seg=0111111; ones=4'hA -> slot0 seg=0111111.
//  5 All inputs 0 -> expired=1 after boundary; an forced 1111 for 8 cycles
//    every 16; set ones=1 -> at next boundary expired=0, blink stops, phase=0.
//  6 en=0 mid-frame -> an=1111 next edge, slot keeps advancing; en=1 resumes
//    at correct slot; reset asserted at slot2 -> next edge blank, slot=0.

Source files
------------

// File: rtl/time_digit_display.sv
// time_digit_display: snapshots three BCD time digits once per scan frame and multiplexes them as M.SS, blinking at 0.00
module time_digit_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] min_digit,
  input  logic [3:0] tens_digit,
  input  logic [3:0] ones_digit,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       expired
);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] DARK = 7'h7F;
  localparam logic [6:0] DASH = 7'b0111111;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic expired_q, expired_d, phase_q, phase_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic ref_tc, blink_tc, frame_wrap, blank;

  function automatic logic [6:0] dec(input logic [3:0] d, input logic [3:0] lim);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = DASH;
    endcase
    return d > lim ? DASH : s;
  endfunction

  always_comb begin
    ref_tc      = ref_cnt_q == RW'(REFRESH_DIV - 1);
    ref_cnt_d   = ref_tc ? '0 : ref_cnt_q + 1'b1;
    slot_d      = ref_tc ? slot_q + 2'd1 : slot_q;
    frame_wrap  = ref_tc && slot_q == 2'd3;
    min_d       = frame_wrap ? min_digit : min_q;
    tens_d      = frame_wrap ? tens_digit : tens_q;
    ones_d      = frame_wrap ? ones_digit : ones_q;
    expired_d   = min_d == 4'd0 && tens_d == 4'd0 && ones_d == 4'd0;
    // blink restarts from the visible phase whenever the display leaves 0.00
    blink_tc    = blink_cnt_q == BW'(BLINK_DIV - 1);
    blink_cnt_d = (!expired_q || blink_tc) ? '0 : blink_cnt_q + 1'b1;
    phase_d     = expired_q && (phase_q ^ blink_tc);
    blank       = !en || (expired_q && phase_q);
    an_d        = blank ? 4'b1111 :
                  slot_q == 2'd0 ? 4'b1110 :
                  slot_q == 2'd1 ? 4'b1101 :
                  slot_q == 2'd2 ? 4'b1011 : 4'b1111;
    seg_d       = blank ? DARK :
                  slot_q == 2'd0 ? dec(ones_q, 4'd9) :
                  slot_q == 2'd1 ? dec(tens_q, 4'd5) :
                  slot_q == 2'd2 ? dec(min_q, 4'd9) : DARK;
    dp_d        = blank || slot_q != 2'd2;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ref_cnt_q   <= '0;
      slot_q      <= '0;
      min_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      expired_q   <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= DARK;
      dp_q        <= 1'b1;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      slot_q      <= slot_d;
      min_q       <= min_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      expired_q   <= expired_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign expired = expired_q;
endmodule

// File: tb/tb_time_digit_display.sv
// tb_time_digit_display: directed checks of scan timing, snapshot, decode, blink, enable and reset
module tb_time_digit_display;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic [3:0] min_digit = 4'd0, tens_digit = 4'd0, ones_digit = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, expired;
  int checks = 0, errors = 0, cyc = 0;

  localparam logic [11:0] BLANK = {4'b1111, 7'h7F, 1'b1};

  time_digit_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk_in(clk_in), .reset(reset), .en(en),
    .min_digit(min_digit), .tens_digit(tens_digit), .ones_digit(ones_digit),
    .an(an), .seg(seg), .dp(dp), .expired(expired)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step_to(input int k);
    while (cyc < k) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
  endtask

  initial begin
    repeat (3) begin @(posedge clk_in); #1; end
    check("rst_disp", {an, seg, dp}, BLANK);
    check("rst_exp", {11'd0, expired}, 12'd0);
    reset = 1'b0;
    min_digit = 4'd1; tens_digit = 4'd2; ones_digit = 4'd3;
    step_to(1);
    check("e1_disp", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    check("e1_exp", {11'd0, expired}, 12'd1);
    step_to(9);
    check("e9_vis", {an, seg, dp}, {4'b1011, 7'b1000000, 1'b0});
    step_to(10);
    check("e10_blink", {an, seg, dp}, BLANK);
    step_to(16);
    check("e16_exp", {11'd0, expired}, 12'd0);
    step_to(17);
    check("f2_s0a", {an, seg, dp}, {4'b1110, 7'b0110000, 1'b1});
    step_to(20);
    check("f2_s0b", {an, seg, dp}, {4'b1110, 7'b0110000, 1'b1});
    step_to(21);
    check("f2_s1", {an, seg, dp}, {4'b1101, 7'b0100100, 1'b1});
    ones_digit = 4'd7; min_digit = 4'd5;
    step_to(25);
    check("f2_s2_notear", {an, seg, dp}, {4'b1011, 7'b1111001, 1'b0});
    step_to(29);
    check("f2_s3", {an, seg, dp}, BLANK);
    step_to(33);
    check("f3_s0", {an, seg, dp}, {4'b1110, 7'b1111000, 1'b1});
    tens_digit = 4'd6; ones_digit = 4'hA;
    step_to(37);
    check("f3_s1", {an, seg, dp}, {4'b1101, 7'b0100100, 1'b1});
    step_to(41);
    check("f3_s2", {an, seg, dp}, {4'b1011, 7'b0010010, 1'b0});
    step_to(49);
    check("f4_ones_dash", {an, seg, dp}, {4'b1110, 7'b0111111, 1'b1});
    step_to(53);
    check("f4_tens_dash", {an, seg, dp}, {4'b1101, 7'b0111111, 1'b1});
    step_to(57);
    check("f4_s2", {an, seg, dp}, {4'b1011, 7'b0010010, 1'b0});
    min_digit = 4'd0; tens_digit = 4'd0; ones_digit = 4'd0;
    step_to(64);
    check("e64_exp", {11'd0, expired}, 12'd1);
    step_to(65);
    check("e65_vis", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    step_to(72);
    check("e72_vis", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    step_to(73);
    check("e73_blank", {an, seg, dp}, BLANK);
    step_to(80);
    check("e80_blank", {an, seg, dp}, BLANK);
    step_to(81);
    check("e81_vis", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    ones_digit = 4'd1;
    step_to(96);
    check("e96_exp", {11'd0, expired}, 12'd0);
    step_to(97);
    check("e97_vis", {an, seg, dp}, {4'b1110, 7'b1111001, 1'b1});
    en = 1'b0;
    step_to(98);
    check("en0_a", {an, seg, dp}, BLANK);
    step_to(102);
    check("en0_b", {an, seg, dp}, BLANK);
    en = 1'b1;
    step_to(103);
    check("en1_slot", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    step_to(105);
    check("noblink_s2", {an, seg, dp}, {4'b1011, 7'b1000000, 1'b0});
    reset = 1'b1;
    step_to(106);
    check("mid_rst_disp", {an, seg, dp}, BLANK);
    check("mid_rst_exp", {11'd0, expired}, 12'd0);
    reset = 1'b0;
    step_to(107);
    check("post_rst_disp", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    check("post_rst_exp", {11'd0, expired}, 12'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
